// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side stream adapter: widths, buffer
// state encoding and the free-slot helper.
package fifo_rd_stream_pkg;

  localparam int unsigned FIFO_DATA_W = 3;
  localparam int unsigned BUF_OCC_W   = 2;
  localparam int unsigned SLOT_W      = 3;

  typedef enum logic [BUF_OCC_W-1:0] {
    BUF_E = 2'd0,
    BUF_O = 2'd1,
    BUF_T = 2'd2
  } buf_state_t;

  // Space left for a new read once this cycle's pop is accounted for.
  // The invariant occ + inflight <= depth keeps the result from wrapping.
  function automatic logic [SLOT_W-1:0] free_slots(
    input logic [SLOT_W-1:0]    depth,
    input logic [BUF_OCC_W-1:0] occ,
    input logic                 infl,
    input logic                 pop
  );
    return depth - {1'b0, occ} - {2'b00, infl} + {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_rd_stream_buf2.sv
// Two-entry shift buffer. Entry 0 is the head presented downstream, and it
// holds steady while the sink stalls.
module stream_buf2
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_push,
  input  logic [DATA_W-1:0]    i_data,
  input  logic                 i_pop,
  output logic [DATA_W-1:0]    o_head,
  output logic                 o_valid,
  output logic [BUF_OCC_W-1:0] o_occ
);

  buf_state_t            r_state;
  logic [DATA_W-1:0]     r_ent0;
  logic [DATA_W-1:0]     r_ent1;
  logic                  r_valid;
  logic [BUF_OCC_W-1:0]  r_occ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= BUF_E;
      r_ent0  <= '0;
      r_ent1  <= '0;
      r_valid <= 1'b0;
      r_occ   <= '0;
    end else if (i_clear) begin
      r_state <= BUF_E;
      r_valid <= 1'b0;
      r_occ   <= '0;
    end else begin
      case (r_state)
        BUF_E: begin
          if (i_push) begin
            r_ent0  <= i_data;
            r_state <= BUF_O;
            r_valid <= 1'b1;
            r_occ   <= 2'd1;
          end
        end
        BUF_O: begin
          if (i_push && !i_pop) begin
            r_ent1  <= i_data;
            r_state <= BUF_T;
            r_occ   <= 2'd2;
          end else if (i_push && i_pop) begin
            r_ent0 <= i_data;
          end else if (i_pop) begin
            r_state <= BUF_E;
            r_valid <= 1'b0;
            r_occ   <= 2'd0;
          end
        end
        BUF_T: begin
          // A push here is excluded by the slot guard; it is still absorbed
          // safely when it rides along with a pop.
          if (i_pop) begin
            r_ent0 <= r_ent1;
            if (i_push) begin
              r_ent1 <= i_data;
            end else begin
              r_state <= BUF_O;
              r_occ   <= 2'd1;
            end
          end
        end
        default: begin
          r_state <= BUF_E;
          r_valid <= 1'b0;
          r_occ   <= '0;
        end
      endcase
    end
  end

  assign o_head  = r_ent0;
  assign o_valid = r_valid;
  assign o_occ   = r_occ;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: issues FIFO reads and streams the words out on
// valid/ready with no bubbles, hiding the FIFO's 1-cycle read latency.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W,
  parameter int unsigned BUF_D  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [DATA_W-1:0]    fifo_data,
  output logic                 fifo_r_en,
  input  logic                 flush,
  output logic                 m_valid,
  output logic [DATA_W-1:0]    m_data,
  input  logic                 m_ready,
  output logic [BUF_OCC_W-1:0] buf_occ
);

  logic              r_inflight;
  logic              w_pop;
  logic [SLOT_W-1:0] w_slots;
  logic              w_rd;

  assign w_pop   = m_valid & m_ready;
  assign w_slots = free_slots(SLOT_W'(BUF_D), buf_occ, r_inflight, w_pop);
  // Gating with rst keeps the read strobe low through an async reset.
  assign w_rd      = rst & ~fifo_empty & ~flush & (w_slots != '0);
  assign fifo_r_en = w_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= 1'b0;
    end else if (flush) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd;
    end
  end

  stream_buf2 #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_clear (flush),
    .i_push  (r_inflight),
    .i_data  (fifo_data),
    .i_pop   (w_pop),
    .o_head  (m_data),
    .o_valid (m_valid),
    .o_occ   (buf_occ)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based 4-deep FIFO feeds the DUT and a
// queue model of owed words predicts every output each cycle.
module tb_fifo_rd_stream;

  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_r_en;
  logic          flush = 1'b0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic [1:0]    buf_occ;

  logic          wr = 1'b0;
  logic [DW-1:0] wdata = '0;

  int nchecks = 0;
  int nerr    = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] mbuf[$];
  bit            minfl = 1'b0;
  logic [DW-1:0] minfl_d = '0;
  bit            ren_s = 1'b0;

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .DATA_W(DW),
    .BUF_D (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .buf_occ    (buf_occ)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Counted FIFO with registered data_out, reset by the same rst.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      fifo_data  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (ren_s && q.size() > 0) fifo_data <= q.pop_front();
      if (wr && q.size() < 4) q.push_back(wdata);
      fifo_empty <= (q.size() == 0);
    end
  end

  // Model: mbuf holds words already delivered to the buffer, minfl/minfl_d the
  // word read but not yet captured.
  always @(negedge clk) begin
    int occ;
    bit pop;
    int slots;
    bit eren;
    if (!rst) begin
      mbuf.delete();
      minfl = 1'b0;
      ren_s = 1'b0;
    end else begin
      occ   = mbuf.size();
      pop   = (occ != 0) && m_ready;
      slots = 2 - occ - int'(minfl) + int'(pop);
      eren  = !fifo_empty && !flush && (slots > 0);
      chk("m_valid", m_valid, occ != 0);
      chk("buf_occ", buf_occ, occ);
      if (occ != 0) chk("m_data", m_data, mbuf[0]);
      chk("fifo_r_en", fifo_r_en, eren);
      if (fifo_empty) chk("ren_on_empty", fifo_r_en, 0);
      ren_s = fifo_r_en;
      if (flush) begin
        mbuf.delete();
      end else begin
        if (pop) void'(mbuf.pop_front());
        if (minfl) mbuf.push_back(minfl_d);
      end
      minfl = fifo_r_en && !flush;
      if (fifo_r_en && q.size() > 0) minfl_d = q[0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [DW-1:0] d);
    wr    = 1'b1;
    wdata = d;
    tick();
    wr = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset values
    repeat (3) tick();
    chk("rst_valid", m_valid, 0);
    chk("rst_occ", buf_occ, 0);
    chk("rst_ren", fifo_r_en, 0);
    chk("rst_data", m_data, 0);
    rst = 1'b1;
    tick();

    // Latency: read strobe right after the write lands, word two cycles later
    m_ready = 1'b1;
    put(3'd5);
    @(negedge clk); chk("lat_ren", fifo_r_en, 1);
    tick();
    @(negedge clk); chk("lat_gap", m_valid, 0);
    tick();
    @(negedge clk); chk("lat_valid", m_valid, 1); chk("lat_data", m_data, 5);
    tick();
    @(negedge clk); chk("lat_popped", m_valid, 0);
    tick();

    // Streaming 0..7 with no bubble after the first word
    fork
      begin
        for (int k = 0; k < 8; k++) put(DW'(k));
      end
      begin
        n = 0;
        @(negedge clk);
        while (!m_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("stream_start", n < 20, 1);
        for (int k = 0; k < 8; k++) begin
          chk("stream_valid", m_valid, 1);
          chk("stream_data", m_data, k);
          if (k < 7) @(negedge clk);
        end
      end
    join
    repeat (4) tick();

    // Backpressure
    m_ready = 1'b0;
    for (int k = 1; k <= 4; k++) put(DW'(k));
    repeat (6) tick();
    @(negedge clk);
    chk("bp_occ", buf_occ, 2);
    chk("bp_ren", fifo_r_en, 0);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 1);
    tick();
    m_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("bp_drain_valid", m_valid, 1);
      chk("bp_drain_data", m_data, k);
    end
    tick();
    repeat (3) tick();

    // Flush with a full buffer discards both buffered words
    m_ready = 1'b0;
    for (int k = 2; k <= 5; k++) put(DW'(k));
    repeat (6) tick();
    @(negedge clk); chk("fl_pre_occ", buf_occ, 2);
    tick();
    flush = 1'b1;
    @(negedge clk); chk("fl_ren", fifo_r_en, 0);
    tick();
    flush = 1'b0;
    @(negedge clk); chk("fl_valid", m_valid, 0); chk("fl_occ", buf_occ, 0);
    tick();
    m_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fl_next_seen", n < 20, 1);
    chk("fl_next_data", m_data, 4);

    // Drain to empty
    n = 0;
    @(negedge clk);
    while (!(fifo_empty && !m_valid) && n < 20) begin
      if (fifo_empty) chk("drain_empty_ren", fifo_r_en, 0);
      @(negedge clk);
      n++;
    end
    chk("drain_done", n < 20, 1);
    chk("drain_ren", fifo_r_en, 0);
    chk("drain_valid", m_valid, 0);
    tick();

    // Async reset mid-transfer
    m_ready = 1'b0;
    for (int k = 1; k <= 4; k++) put(DW'(k));
    repeat (5) tick();
    m_ready = 1'b1;
    #2;
    chk("amid_pre_ren", fifo_r_en, 1);
    rst = 1'b0;
    #1;
    chk("amid_valid", m_valid, 0);
    chk("amid_occ", buf_occ, 0);
    chk("amid_ren", fifo_r_en, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      wr      = ($urandom_range(0, 99) < 60);
      wdata   = DW'($urandom);
      m_ready = ($urandom_range(0, 99) < 70);
      flush   = ($urandom_range(0, 99) < 4);
      tick();
    end
    wr = 1'b0;
    flush = 1'b0;
    m_ready = 1'b1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
